// File: rtl/cd_dma_engine_if.sv
// Signal bundle between the CD DMA transfer engine, its register file and the 68k-side memory bus.
// The master modport is the engine's view; slave is the register file / bus environment.
interface cd_dma_engine_if;
    logic        START;
    logic        MODE;
    logic [23:0] SOURCE;
    logic [23:0] DEST;
    logic [15:0] VALUE;
    logic [23:0] COUNT;
    logic        BUS_REQ;
    logic        BUS_GRANT;
    logic [22:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;
    logic        MEM_RD;
    logic        MEM_WR;
    logic        MEM_ACK;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;

    modport master (
        input  START, MODE, SOURCE, DEST, VALUE, COUNT,
        input  BUS_GRANT, MEM_RDATA, MEM_ACK,
        output BUS_REQ, MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WR,
        output BUSY, DONE, ERROR
    );

    modport slave (
        output START, MODE, SOURCE, DEST, VALUE, COUNT,
        output BUS_GRANT, MEM_RDATA, MEM_ACK,
        input  BUS_REQ, MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WR,
        input  BUSY, DONE, ERROR
    );
endinterface

// File: rtl/cd_dma_engine.sv
// CD-system DMA transfer engine: arbitrates for the 68k bus and moves 16-bit words
// (copy or fill) with single read/write cycles, reporting busy, done and timeout error.
module cd_dma_engine #(
    parameter int TIMEOUT = 1023
) (
    input logic             CLK,
    input logic             nRESET,
    cd_dma_engine_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        NEXT,
        RELEASE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [22:0]   src;
    logic [22:0]   dst;
    logic [15:0]   val;
    logic [15:0]   data;
    logic [23:0]   cnt;
    logic          mode;
    logic          req_made;
    logic [TW-1:0] tmo;
    logic          tmo_hit;
    logic          error_q;
    logic          done_q;

    logic          bus_req;
    logic          mem_rd;
    logic          mem_wr;
    logic [22:0]   mem_addr;
    logic [15:0]   mem_wdata;

    // Byte-address bit 0 is meaningless for word transfers.
    logic          unused_addr_lsb;
    assign unused_addr_lsb = bus.SOURCE[0] ^ bus.DEST[0];

    assign tmo_hit = (tmo == TW'(TIMEOUT - 1));

    // NOTE: state is the only register here; strobes/address decode from it, so an
    // asynchronous reset drops them immediately without extra output flops.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nx;
    end

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        bus_req   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (bus.START) state_nx = (bus.COUNT == '0) ? RELEASE : REQ;
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus.BUS_GRANT) state_nx = mode ? WRITE : READ;
            end
            READ: begin
                bus_req  = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = src;
                if (bus.MEM_ACK)  state_nx = WRITE;
                else if (tmo_hit) state_nx = RELEASE;
            end
            WRITE: begin
                bus_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = dst;
                mem_wdata = mode ? val : data;
                if (bus.MEM_ACK)  state_nx = NEXT;
                else if (tmo_hit) state_nx = RELEASE;
            end
            NEXT: begin
                // Keep requesting while waiting for a regrant so progress is not lost.
                bus_req = 1'b1;
                if (cnt == 24'd1)       state_nx = RELEASE;
                else if (bus.BUS_GRANT) state_nx = mode ? WRITE : READ;
                else                    state_nx = REQ;
            end
            RELEASE: begin
                if (!req_made || !bus.BUS_GRANT) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            src      <= '0;
            dst      <= '0;
            val      <= '0;
            data     <= '0;
            cnt      <= '0;
            mode     <= 1'b0;
            req_made <= 1'b0;
            tmo      <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == RELEASE) && (state_nx == IDLE);

            if ((state == READ || state == WRITE) && !bus.MEM_ACK) tmo <= tmo + TW'(1);
            else                                                   tmo <= '0;

            unique case (state)
                IDLE: begin
                    if (bus.START) begin
                        src      <= bus.SOURCE[23:1];
                        dst      <= bus.DEST[23:1];
                        val      <= bus.VALUE;
                        cnt      <= bus.COUNT;
                        mode     <= bus.MODE;
                        req_made <= (bus.COUNT != '0);
                        error_q  <= 1'b0;
                    end
                end
                READ: begin
                    if (bus.MEM_ACK)  data    <= bus.MEM_RDATA;
                    else if (tmo_hit) error_q <= 1'b1;
                end
                WRITE: begin
                    if (!bus.MEM_ACK && tmo_hit) error_q <= 1'b1;
                end
                NEXT: begin
                    src <= src + 23'd1;
                    dst <= dst + 23'd1;
                    cnt <= cnt - 24'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.BUS_REQ   = bus_req;
    assign bus.MEM_RD    = mem_rd;
    assign bus.MEM_WR    = mem_wr;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = mem_wdata;
    assign bus.BUSY      = (state != IDLE);
    assign bus.DONE      = done_q;
    assign bus.ERROR     = error_q;
endmodule

// File: tb/tb_cd_dma_engine.sv
// Directed bench for cd_dma_engine: a small bus model grants and acknowledges,
// and one linear stimulus sequence checks transfers against hand-computed values.
module tb_cd_dma_engine;
    logic CLK    = 1'b0;
    logic nRESET = 1'b0;

    cd_dma_engine_if bus ();

    cd_dma_engine #(.TIMEOUT(8)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus.master)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        wr;
        logic [22:0] addr;
        logic [15:0] data;
    } acc_t;

    acc_t        acc_log[$];
    logic [15:0] rdata_q[$];

    int checks      = 0;
    int errors      = 0;
    int cycle       = 0;
    int start_cycle = 0;
    int grant_delay = 2;
    int ack_delay   = 0;
    bit grant_block = 1'b0;
    bit ack_en      = 1'b1;
    bit both_seen   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
        cycle++;
    endtask

    // Bus model: grants grant_delay cycles after a request, acknowledges after ack_delay wait states.
    initial begin : bus_model
        int   req_cnt;
        int   wait_cnt;
        acc_t e;
        req_cnt       = 0;
        wait_cnt      = 0;
        bus.BUS_GRANT = 1'b0;
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.MEM_RD === 1'b1 && bus.MEM_WR === 1'b1) both_seen = 1'b1;
            if (bus.BUS_REQ !== 1'b1 || grant_block) begin
                bus.BUS_GRANT = 1'b0;
                req_cnt       = 0;
            end else if (req_cnt >= grant_delay) begin
                bus.BUS_GRANT = 1'b1;
            end else begin
                req_cnt++;
            end
            if ((bus.MEM_RD === 1'b1 || bus.MEM_WR === 1'b1) && ack_en && wait_cnt >= ack_delay) begin
                bus.MEM_ACK = 1'b1;
                wait_cnt    = 0;
                e.addr      = bus.MEM_ADDR;
                if (bus.MEM_RD === 1'b1) begin
                    bus.MEM_RDATA = 16'h0000;
                    if (rdata_q.size() > 0) bus.MEM_RDATA = rdata_q.pop_front();
                    e.wr   = 1'b0;
                    e.data = bus.MEM_RDATA;
                end else begin
                    e.wr   = 1'b1;
                    e.data = bus.MEM_WDATA;
                end
                acc_log.push_back(e);
            end else if (bus.MEM_RD === 1'b1 || bus.MEM_WR === 1'b1) begin
                bus.MEM_ACK = 1'b0;
                wait_cnt++;
            end else begin
                bus.MEM_ACK = 1'b0;
                wait_cnt    = 0;
            end
        end
    end

    task automatic do_start(input logic mode, input logic [23:0] src, input logic [23:0] dst,
                            input logic [15:0] val, input logic [23:0] cnt);
        bus.MODE   = mode;
        bus.SOURCE = src;
        bus.DEST   = dst;
        bus.VALUE  = val;
        bus.COUNT  = cnt;
        bus.START  = 1'b1;
        start_cycle = cycle;
        tick();
        // Scramble the inputs: the running transfer must not see them.
        bus.START  = 1'b0;
        bus.MODE   = ~mode;
        bus.SOURCE = 24'h5A5A5A;
        bus.DEST   = 24'h0F0F0E;
        bus.VALUE  = 16'hDEAD;
        bus.COUNT  = 24'd7;
    endtask

    task automatic expect_done(input string tag, input int exp_cycle);
        while (bus.DONE !== 1'b1 && (cycle - start_cycle) < 300) tick();
        check({tag, " done cycle"}, cycle - start_cycle, exp_cycle);
        check({tag, " busy at done"}, bus.BUSY, 0);
        check({tag, " req at done"}, bus.BUS_REQ, 0);
        tick();
        check({tag, " done pulse width"}, bus.DONE, 0);
    endtask

    task automatic check_acc(input string tag, input int idx, input logic wr,
                             input logic [22:0] addr, input logic [15:0] data);
        acc_t e;
        e = '0;
        if (idx < acc_log.size()) e = acc_log[idx];
        check($sformatf("%s[%0d] kind", tag, idx), e.wr, wr);
        check($sformatf("%s[%0d] addr", tag, idx), e.addr, addr);
        check($sformatf("%s[%0d] data", tag, idx), e.data, data);
    endtask

    initial begin : stimulus
        int n;
        bit held;
        bus.START  = 1'b0;
        bus.MODE   = 1'b0;
        bus.SOURCE = '0;
        bus.DEST   = '0;
        bus.VALUE  = '0;
        bus.COUNT  = '0;

        // Reset values
        #12;
        check("reset BUS_REQ", bus.BUS_REQ, 0);
        check("reset MEM_RD", bus.MEM_RD, 0);
        check("reset MEM_WR", bus.MEM_WR, 0);
        check("reset MEM_ADDR", bus.MEM_ADDR, 0);
        check("reset MEM_WDATA", bus.MEM_WDATA, 0);
        check("reset BUSY", bus.BUSY, 0);
        check("reset DONE", bus.DONE, 0);
        check("reset ERROR", bus.ERROR, 0);
        nRESET = 1'b1;
        tick();

        // Fill, 4 words, zero-wait ACK: W/N pairs in cycles 4..11, RELEASE 12, DONE 13
        acc_log.delete();
        ack_delay = 0;
        do_start(1'b1, 24'h000000, 24'h100000, 16'hA5A5, 24'd4);
        check("fill BUSY c1", bus.BUSY, 1);
        check("fill BUS_REQ c1", bus.BUS_REQ, 1);
        expect_done("fill", 13);
        check("fill ERROR", bus.ERROR, 0);
        check("fill count", acc_log.size(), 4);
        for (int i = 0; i < 4; i++) check_acc("fill", i, 1'b1, 23'h080000 + 23'(i), 16'hA5A5);

        // Copy, 3 words, two wait states per access: 7 cycles/word from cycle 4, DONE 26
        acc_log.delete();
        rdata_q = '{16'h1111, 16'h2222, 16'h3333};
        ack_delay = 2;
        do_start(1'b0, 24'h200000, 24'h300000, 16'h0000, 24'd3);
        expect_done("copy", 26);
        check("copy count", acc_log.size(), 6);
        check_acc("copy", 0, 1'b0, 23'h100000, 16'h1111);
        check_acc("copy", 1, 1'b1, 23'h180000, 16'h1111);
        check_acc("copy", 2, 1'b0, 23'h100001, 16'h2222);
        check_acc("copy", 3, 1'b1, 23'h180001, 16'h2222);
        check_acc("copy", 4, 1'b0, 23'h100002, 16'h3333);
        check_acc("copy", 5, 1'b1, 23'h180002, 16'h3333);

        // COUNT = 0: no request, no strobes, DONE two cycles after START
        acc_log.delete();
        ack_delay = 0;
        do_start(1'b1, 24'h000000, 24'h123456, 16'h7777, 24'd0);
        check("count0 BUSY c1", bus.BUSY, 1);
        check("count0 BUS_REQ c1", bus.BUS_REQ, 0);
        check("count0 MEM_WR c1", bus.MEM_WR, 0);
        expect_done("count0", 2);
        check("count0 accesses", acc_log.size(), 0);

        // Timeout: ACK never returned, read strobe held 8 cycles (4..11), DONE 13
        ack_en = 1'b0;
        do_start(1'b0, 24'h000010, 24'h000020, 16'h0000, 24'd1);
        n = 0;
        while (bus.MEM_RD !== 1'b1 && n < 20) begin tick(); n++; end
        check("timeout rd seen", bus.MEM_RD, 1);
        n = 0;
        while (bus.MEM_RD === 1'b1 && n < 50) begin n++; tick(); end
        check("timeout rd cycles", n, 8);
        check("timeout ERROR set", bus.ERROR, 1);
        check("timeout req dropped", bus.BUS_REQ, 0);
        expect_done("timeout", 13);
        check("timeout ERROR sticky", bus.ERROR, 1);
        ack_en = 1'b1;
        do_start(1'b1, 24'h000000, 24'h000000, 16'h0000, 24'd0);
        check("restart clears ERROR", bus.ERROR, 0);
        expect_done("clear", 2);

        // Grant withdrawn after word 1 of a 3-word fill; regrant after cycle 10 -> DONE 19
        acc_log.delete();
        do_start(1'b1, 24'h000000, 24'h000400, 16'h5A5A, 24'd3);
        n = 0;
        while (acc_log.size() < 1 && n < 50) begin tick(); n++; end
        grant_block = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!(bus.BUS_REQ === 1'b1 && bus.MEM_WR === 1'b0 && bus.MEM_RD === 1'b0)) held = 1'b0;
        end
        check("withdraw req held no strobe", held, 1);
        check("withdraw words before regrant", acc_log.size(), 1);
        grant_block = 1'b0;
        expect_done("withdraw", 19);
        check("withdraw count", acc_log.size(), 3);
        for (int i = 0; i < 3; i++) check_acc("withdraw", i, 1'b1, 23'h000200 + 23'(i), 16'h5A5A);

        // Destination wraps from the top word address to zero
        acc_log.delete();
        do_start(1'b1, 24'h000000, 24'hFFFFFE, 16'h1234, 24'd2);
        expect_done("wrap", 9);
        check("wrap count", acc_log.size(), 2);
        check_acc("wrap", 0, 1'b1, 23'h7FFFFF, 16'h1234);
        check_acc("wrap", 1, 1'b1, 23'h000000, 16'h1234);

        // Reset asserted mid-WRITE drops everything asynchronously
        ack_en = 1'b0;
        do_start(1'b1, 24'h000000, 24'h000800, 16'hBEEF, 24'd2);
        n = 0;
        while (bus.MEM_WR !== 1'b1 && n < 20) begin tick(); n++; end
        check("rst pre MEM_WR", bus.MEM_WR, 1);
        check("rst pre MEM_WDATA", bus.MEM_WDATA, 16'hBEEF);
        #3;
        nRESET = 1'b0;
        #1;
        check("rst mid BUS_REQ", bus.BUS_REQ, 0);
        check("rst mid MEM_WR", bus.MEM_WR, 0);
        check("rst mid MEM_ADDR", bus.MEM_ADDR, 0);
        check("rst mid MEM_WDATA", bus.MEM_WDATA, 0);
        check("rst mid BUSY", bus.BUSY, 0);
        #1;
        nRESET = 1'b1;
        ack_en = 1'b1;
        tick();
        tick();

        // Normal run after reset; a second START while busy is ignored
        acc_log.delete();
        do_start(1'b1, 24'h000000, 24'h000800, 16'hBEEF, 24'd2);
        bus.COUNT = 24'd5;
        bus.DEST  = 24'h000000;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        expect_done("restart", 9);
        check("restart count", acc_log.size(), 2);
        check_acc("restart", 0, 1'b1, 23'h000400, 16'hBEEF);
        check_acc("restart", 1, 1'b1, 23'h000401, 16'hBEEF);
        tick();
        tick();
        check("restart idle after", bus.BUSY, 0);

        check("strobe exclusivity", both_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cd_dma_engine.md
# cd_dma_engine

Transfer engine for the CD-system DMA controller. It sits directly downstream of the DMA register file: it takes the latched source, destination, fill value, word count and decoded mode, then moves 16-bit words over the 68k-side memory bus. It arbitrates for the bus with a request/grant handshake, runs single-word read/write cycles with acknowledge, and reports busy, done and error status back to the register file.

## Interface
Parameters:
- TIMEOUT, 1023: maximum cycles a strobe may wait for MEM_ACK before the transfer aborts.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; begin transfer (generated upstream on the RUN write).
- MODE  in  1  0 = copy (SOURCE→DEST), 1 = fill (VALUE→DEST).
- SOURCE  in  24  byte address; bit 0 ignored.
- DEST  in  24  byte address; bit 0 ignored.
- VALUE  in  16  fill word.
- COUNT  in  24  number of words to transfer.
- BUS_REQ  out  1  bus request to the 68k arbiter.
- BUS_GRANT  in  1  bus grant.
- MEM_ADDR  out  23  word address [23:1].
- MEM_WDATA  out  16  write data.
- MEM_RDATA  in  16  read data, valid in the MEM_ACK cycle.
- MEM_RD  out  1  read strobe.
- MEM_WR  out  1  write strobe.
- MEM_ACK  in  1  access acknowledge, one cycle.
- BUSY  out  1  high from the cycle after START until DONE.
- DONE  out  1  one-cycle completion pulse.
- ERROR  out  1  sticky timeout flag; cleared by the next accepted START.

## Operation
- States: IDLE, REQ, READ, WRITE, NEXT, RELEASE.
- IDLE: on START, the engine latches SOURCE[23:1], DEST[23:1], VALUE, COUNT and MODE into internal registers, clears ERROR and goes to REQ. If COUNT = 0, it goes straight to RELEASE without ever asserting BUS_REQ.
- REQ: BUS_REQ = 1. When BUS_GRANT is sampled high, the engine goes to READ (copy) or WRITE (fill).
- READ: MEM_RD = 1 and MEM_ADDR = src. When MEM_ACK is sampled, the engine latches MEM_RDATA into the data register and goes to WRITE.
- WRITE: MEM_WR = 1, MEM_ADDR = dst, MEM_WDATA = data register (copy) or VALUE (fill). When MEM_ACK is sampled, the engine goes to NEXT.
- NEXT: src += 1 and dst += 1 (word addresses, 23-bit, wrap modulo 2^23 with no flag); cnt -= 1.
  - If the new cnt = 0, go to RELEASE.
  - Else if BUS_GRANT = 1, go to READ/WRITE.
  - Else go to REQ; progress is kept and the engine waits for a regrant.
- RELEASE: BUS_REQ = 0. Once BUS_GRANT is sampled low (or immediately if never requested), DONE pulses for one cycle and the engine returns to IDLE.
- Timeout: a counter resets on entry to READ/WRITE and increments each cycle without MEM_ACK. At TIMEOUT, the strobe drops, ERROR is set, and the engine goes to RELEASE. DONE still pulses.
- START while BUSY is ignored. Input changes after START have no effect on a running transfer.
- Strobes are mutually exclusive. MEM_RD and MEM_WR are never both high.

## Timing
- Reset values: BUS_REQ = 0, MEM_RD = 0, MEM_WR = 0, MEM_ADDR = 0, MEM_WDATA = 0, BUSY = 0, DONE = 0, ERROR = 0, state IDLE. Reset asserted mid-transfer drops every strobe and request immediately (asynchronously).
- Start latency:
  - START at cycle 0 → BUSY = 1 and BUS_REQ = 1 at cycle 1.
  - BUS_GRANT sampled at cycle n → strobe high at cycle n+1.
- Strobe timing:
  - A strobe and its address/data are registered and held stable until the cycle MEM_ACK is sampled.
  - The strobe is low in the following cycle (NEXT or the state change).
  - MEM_ACK in the first strobe cycle is legal.
- Per-word cost with zero-wait ACK: fill = 2 cycles (WRITE, NEXT); copy = 3 cycles (READ, WRITE, NEXT).
- MEM_ACK sampled while no strobe is active is ignored.
- BUSY falls in the same cycle DONE is asserted.

## Test plan
- Fill: DEST = 0x100000, VALUE = 0xA5A5, COUNT = 4, grant after 2 cycles, ACK zero-wait → writes of 0xA5A5 to word addresses 0x080000–0x080003, one DONE pulse, ERROR = 0, BUS_REQ low before DONE.
- Copy with wait states: SOURCE = 0x200000, DEST = 0x300000, COUNT = 3, ACK delayed 2 cycles, RDATA = 0x1111/0x2222/0x3333 → identical sequence written to 0x180000–0x180002, strict alternation of read then write.
- COUNT = 0 → BUS_REQ never asserted, DONE 2 cycles after START, no strobes.
- Timeout with TIMEOUT = 8, MEM_ACK never returned → MEM_RD drops after 8 cycles, ERROR = 1, DONE pulses. A new START clears ERROR.
- Grant withdrawn after word 1 of a 3-word fill → BUS_REQ stays high, no strobe until regrant, words 2–3 land at the correct addresses. Also: DEST = 0xFFFFFE with COUNT = 2 wraps to word address 0x000000.
- nRESET pulsed during WRITE → all outputs 0 immediately. START after release runs normally. START pulsed while BUSY is ignored.
